// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the Neptune register write-back front end.
package reg_wb_arbiter_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ADD_WIDTH  = 3;
  localparam int unsigned REG_DEPTH  = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_WIDTH  = 8;

  // Per-cycle issue decision taken on the two FIFO heads.
  typedef enum logic [2:0] {
    ISSUE_NONE = 3'd0,
    ISSUE_A    = 3'd1,
    ISSUE_B    = 3'd2,
    ISSUE_AB   = 3'd3,
    ISSUE_COLL = 3'd4
  } issue_e;

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding {add, data} write requests for one producer.
module wb_fifo #(
  parameter int unsigned W     = 19,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_c,
  output logic         empty_c,
  output logic [W-1:0] head_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c = (cnt_q == CNT_W'(0));
  assign head_c  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when it is popped on the same edge.
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are meaningless while the slot is unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Dual-channel write-back arbiter driving the two register array write ports.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned width      = WIDTH,
  parameter int unsigned add_width  = ADD_WIDTH,
  parameter int unsigned fifo_depth = FIFO_DEPTH,
  parameter int unsigned cnt_width  = CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [add_width-1:0] a_add,
  input  logic [width-1:0]     a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [add_width-1:0] b_add,
  input  logic [width-1:0]     b_data,
  output logic                 we1,
  output logic [add_width-1:0] add1,
  output logic [width-1:0]     wr1,
  output logic                 we2,
  output logic [add_width-1:0] add2,
  output logic [width-1:0]     wr2,
  output logic                 idle,
  output logic [cnt_width-1:0] coll_cnt
);

  localparam int unsigned PW = width + add_width;

  logic          a_full, a_empty, b_full, b_empty;
  logic [PW-1:0] a_head, b_head;
  logic          pop_a, pop_b;
  issue_e        issue;

  logic [add_width-1:0] a_head_add, b_head_add;
  logic [width-1:0]     a_head_data, b_head_data;

  logic                 we1_q, we1_d, we2_q, we2_d;
  logic [add_width-1:0] add1_q, add1_d, add2_q, add2_d;
  logic [width-1:0]     wr1_q, wr1_d, wr2_q, wr2_d;
  logic [cnt_width-1:0] coll_cnt_q, coll_cnt_d;

  wb_fifo #(.W(PW), .DEPTH(fifo_depth)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (a_valid),
    .data_i  ({a_add, a_data}),
    .pop_i   (pop_a),
    .full_c  (a_full),
    .empty_c (a_empty),
    .head_c  (a_head)
  );

  wb_fifo #(.W(PW), .DEPTH(fifo_depth)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_valid),
    .data_i  ({b_add, b_data}),
    .pop_i   (pop_b),
    .full_c  (b_full),
    .empty_c (b_empty),
    .head_c  (b_head)
  );

  assign a_ready     = !a_full;
  assign b_ready     = !b_full;
  assign a_head_add  = a_head[PW-1:width];
  assign a_head_data = a_head[width-1:0];
  assign b_head_add  = b_head[PW-1:width];
  assign b_head_data = b_head[width-1:0];

  // Issue decision: a same-address pair lets A go first and holds B one cycle.
  always_comb begin
    issue = ISSUE_NONE;
    case ({!a_empty, !b_empty})
      2'b10:   issue = ISSUE_A;
      2'b01:   issue = ISSUE_B;
      2'b11:   issue = (a_head_add == b_head_add) ? ISSUE_COLL : ISSUE_AB;
      default: issue = ISSUE_NONE;
    endcase
  end

  assign pop_a = (issue == ISSUE_A) || (issue == ISSUE_AB) || (issue == ISSUE_COLL);
  assign pop_b = (issue == ISSUE_B) || (issue == ISSUE_AB);

  // Next-state of the write ports; address/data hold while a port is idle.
  always_comb begin
    we1_d      = pop_a;
    add1_d     = add1_q;
    wr1_d      = wr1_q;
    we2_d      = pop_b;
    add2_d     = add2_q;
    wr2_d      = wr2_q;
    coll_cnt_d = coll_cnt_q;
    if (pop_a) begin
      add1_d = a_head_add;
      wr1_d  = a_head_data;
    end
    if (pop_b) begin
      add2_d = b_head_add;
      wr2_d  = b_head_data;
    end
    if ((issue == ISSUE_COLL) && !(&coll_cnt_q)) begin
      coll_cnt_d = coll_cnt_q + cnt_width'(1);
    end
  end

  // Write-port and collision-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we1_q      <= 1'b0;
      add1_q     <= '0;
      wr1_q      <= '0;
      we2_q      <= 1'b0;
      add2_q     <= '0;
      wr2_q      <= '0;
      coll_cnt_q <= '0;
    end else begin
      we1_q      <= we1_d;
      add1_q     <= add1_d;
      wr1_q      <= wr1_d;
      we2_q      <= we2_d;
      add2_q     <= add2_d;
      wr2_q      <= wr2_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign we1      = we1_q;
  assign add1     = add1_q;
  assign wr1      = wr1_q;
  assign we2      = we2_q;
  assign add2     = add2_q;
  assign wr2      = wr2_q;
  assign coll_cnt = coll_cnt_q;

  // Drain indicator for the pipeline halt logic.
  assign idle = a_empty && b_empty && !we1_q && !we2_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_reg_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [2:0]  a_add = '0, b_add = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        we1, we2, idle;
  logic [2:0]  add1, add2;
  logic [15:0] wr1, wr2;
  logic [7:0]  coll_cnt;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_add    (a_add),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_add    (b_add),
    .b_data   (b_data),
    .we1      (we1),
    .add1     (add1),
    .wr1      (wr1),
    .we2      (we2),
    .add2     (add2),
    .wr2      (wr2),
    .idle     (idle),
    .coll_cnt (coll_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel request queues and the resulting register image.
  logic [18:0] qa[$];
  logic [18:0] qb[$];
  logic        exp_we1 = 0, exp_we2 = 0, exp_idle = 1;
  logic [2:0]  exp_add1 = 0, exp_add2 = 0;
  logic [15:0] exp_wr1 = 0, exp_wr2 = 0;
  logic [7:0]  exp_cnt = 0;
  logic        exp_a_ready = 1, exp_b_ready = 1;
  logic        sa_ready, sb_ready;
  logic [15:0] exp_rf [8];
  logic [15:0] dut_rf [8];

  // Register array as seen by the DUT's write ports.
  always @(posedge clk) begin
    if (we1 === 1'b1) dut_rf[add1] <= wr1;
    if (we2 === 1'b1) dut_rf[add2] <= wr2;
  end

  // The array must never see two writes to one address in one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (we1 === 1'b1 && we2 === 1'b1 && add1 === add2) begin
        errors++;
        $display("FAIL invariant_dual_write: add1=%0d add2=%0d both enabled", add1, add2);
      end
    end
  end

  // One clock: drive inputs, sample ready pre-edge, advance the model, settle.
  task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic bv, input logic [2:0] ba, input logic [15:0] bd);
    logic        ha, hb, pa, pb;
    logic [18:0] r;
    a_valid = av; a_add = aa; a_data = ad;
    b_valid = bv; b_add = ba; b_data = bd;
    exp_a_ready = (qa.size() < DEPTH);
    exp_b_ready = (qb.size() < DEPTH);
    sa_ready = a_ready;
    sb_ready = b_ready;
    @(posedge clk);
    ha = (qa.size() != 0);
    hb = (qb.size() != 0);
    if (ha && hb && qa[0][18:16] == qb[0][18:16]) begin
      pa = 1'b1; pb = 1'b0;
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    end else begin
      pa = ha; pb = hb;
    end
    exp_we1 = pa;
    exp_we2 = pb;
    if (pa) begin
      r = qa.pop_front();
      exp_add1 = r[18:16]; exp_wr1 = r[15:0];
      exp_rf[exp_add1] = exp_wr1;
    end
    if (pb) begin
      r = qb.pop_front();
      exp_add2 = r[18:16]; exp_wr2 = r[15:0];
      exp_rf[exp_add2] = exp_wr2;
    end
    if (av && exp_a_ready) qa.push_back({aa, ad});
    if (bv && exp_b_ready) qb.push_back({ba, bd});
    exp_idle = (qa.size() == 0) && (qb.size() == 0) && !exp_we1 && !exp_we2;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    a_valid = 1'b1; a_add = 3'($urandom); a_data = 16'($urandom);
    b_valid = 1'b1; b_add = 3'($urandom); b_data = 16'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    qa.delete(); qb.delete();
    exp_we1 = 0; exp_we2 = 0; exp_add1 = 0; exp_add2 = 0;
    exp_wr1 = 0; exp_wr2 = 0; exp_cnt = 0; exp_idle = 1;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we1 got=%b exp=0", we1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL reset_we2 got=%b exp=0", we2); end
    checks++; if (coll_cnt !== 8'd0) begin errors++; $display("FAIL reset_coll_cnt got=%0d exp=0", coll_cnt); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    idle_step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_rf[i] !== 16'h0) begin errors++; $display("FAIL reset_no_write r%0d got=%h exp=0", i, dut_rf[i]); end
    end
  endtask

  task automatic test_single();
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL single_we1_early got=%b exp=0", we1); end
    idle_step();
    checks++; if (we1 !== 1'b1) begin errors++; $display("FAIL single_we1 got=%b exp=1", we1); end
    checks++; if (add1 !== 3'd3) begin errors++; $display("FAIL single_add1 got=%0d exp=3", add1); end
    checks++; if (wr1 !== 16'hBEEF) begin errors++; $display("FAIL single_wr1 got=%h exp=beef", wr1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL single_we2 got=%b exp=0", we2); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", idle); end
    idle_step();
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL single_we1_drop got=%b exp=0", we1); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_parallel();
    step(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022);
    idle_step();
    checks++; if (we1 !== 1'b1 || we2 !== 1'b1) begin errors++; $display("FAIL par_we got=%b%b exp=11", we1, we2); end
    checks++; if (add1 !== 3'd1 || wr1 !== 16'h0011) begin errors++; $display("FAIL par_port1 got=%0d/%h exp=1/0011", add1, wr1); end
    checks++; if (add2 !== 3'd2 || wr2 !== 16'h0022) begin errors++; $display("FAIL par_port2 got=%0d/%h exp=2/0022", add2, wr2); end
    checks++; if (coll_cnt !== 8'd0) begin errors++; $display("FAIL par_coll_cnt got=%0d exp=0", coll_cnt); end
    idle_step();
  endtask

  task automatic test_collision();
    step(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
    idle_step();
    checks++; if (we1 !== 1'b1 || add1 !== 3'd5 || wr1 !== 16'h1111) begin errors++; $display("FAIL coll_c1_port1 got=%b/%0d/%h exp=1/5/1111", we1, add1, wr1); end
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL coll_c1_we2 got=%b exp=0", we2); end
    idle_step();
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL coll_c2_we1 got=%b exp=0", we1); end
    checks++; if (we2 !== 1'b1 || add2 !== 3'd5 || wr2 !== 16'h2222) begin errors++; $display("FAIL coll_c2_port2 got=%b/%0d/%h exp=1/5/2222", we2, add2, wr2); end
    checks++; if (coll_cnt !== 8'd1) begin errors++; $display("FAIL coll_cnt got=%0d exp=1", coll_cnt); end
    idle_step();
    checks++; if (dut_rf[5] !== 16'h2222) begin errors++; $display("FAIL coll_r5 got=%h exp=2222", dut_rf[5]); end
  endtask

  task automatic test_backpressure();
    logic [15:0] bdat [3];
    logic [15:0] got[$];
    logic [15:0] ad;
    int          bi;
    bit          saw_low;
    for (int i = 0; i < 3; i++) bdat[i] = 16'hB000 + 16'(i);
    ad = 16'($urandom); bi = 0; saw_low = 0;
    // A keeps colliding on r4, so B fills up and stalls.
    for (int c = 0; c < 320; c++) begin
      step(1'b1, 3'd4, ad, bi < 3, 3'd4, bdat[bi < 3 ? bi : 2]);
      if (sa_ready) ad = 16'($urandom);
      if (bi < 3 && sb_ready) bi++;
      if (!sb_ready) saw_low = 1;
      if (we2 === 1'b1) got.push_back(wr2);
    end
    checks++; if (!saw_low) begin errors++; $display("FAIL bp_b_ready_low never observed b_ready=0"); end
    checks++; if (sb_ready !== exp_b_ready) begin errors++; $display("FAIL bp_b_ready got=%b exp=%b", sb_ready, exp_b_ready); end
    checks++; if (coll_cnt !== 8'd255) begin errors++; $display("FAIL bp_coll_sat got=%0d exp=255", coll_cnt); end
    checks++; if (coll_cnt !== exp_cnt) begin errors++; $display("FAIL bp_coll_model got=%0d exp=%0d", coll_cnt, exp_cnt); end
    // A goes quiet; B drains the rest, bounded.
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 3'd0, 16'h0, bi < 3, 3'd4, bdat[bi < 3 ? bi : 2]);
      if (bi < 3 && sb_ready) bi++;
      if (we2 === 1'b1) got.push_back(wr2);
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_b_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== bdat[i]) begin
        errors++; $display("FAIL bp_b_order idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 16'hxxxx, bdat[i]);
      end
    end
    checks++; if (dut_rf[4] !== 16'hB002) begin errors++; $display("FAIL bp_r4 got=%h exp=b002", dut_rf[4]); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) step(1'b1, 3'd6, 16'hA000 + 16'(c), 1'b1, 3'd6, 16'hD000 + 16'(c));
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL mid_b_full got=%b exp=0", b_ready); end
    apply_reset(1);
    checks++; if (we1 !== 1'b0 || we2 !== 1'b0) begin errors++; $display("FAIL mid_we got=%b%b exp=00", we1, we2); end
    checks++; if (idle !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL mid_flush idle/ar/br got=%b%b%b exp=111", idle, a_ready, b_ready); end
    for (int c = 0; c < 4; c++) begin
      idle_step();
      checks++; if (we1 !== 1'b0 || we2 !== 1'b0) begin errors++; $display("FAIL mid_stale_issue cyc=%0d got=%b%b exp=00", c, we1, we2); end
    end
    step(1'b1, 3'd2, 16'hCAFE, 1'b0, 3'd0, 16'h0);
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL mid_fresh_early got=%b exp=0", we1); end
    idle_step();
    checks++; if (we1 !== 1'b1 || add1 !== 3'd2 || wr1 !== 16'hCAFE) begin errors++; $display("FAIL mid_fresh got=%b/%0d/%h exp=1/2/cafe", we1, add1, wr1); end
    idle_step();
  endtask

  task automatic test_random();
    logic        av = 0, bv = 0;
    logic [2:0]  aa = 0, ba = 0;
    logic [15:0] ad = 0, bd = 0;
    for (int c = 0; c < 600; c++) begin
      // A producer stuck behind a full FIFO holds its request.
      if (!(av && !exp_a_ready)) begin
        av = 1'($urandom_range(0, 1)); aa = 3'($urandom_range(0, 3)); ad = 16'($urandom);
      end
      if (!(bv && !exp_b_ready)) begin
        bv = 1'($urandom_range(0, 1)); ba = 3'($urandom_range(0, 3)); bd = 16'($urandom);
      end
      step(av, aa, ad, bv, ba, bd);
      checks++; if (sa_ready !== exp_a_ready) begin errors++; $display("FAIL rnd_a_ready cyc=%0d got=%b exp=%b", c, sa_ready, exp_a_ready); end
      checks++; if (sb_ready !== exp_b_ready) begin errors++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", c, sb_ready, exp_b_ready); end
      checks++; if (we1 !== exp_we1 || we2 !== exp_we2) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b%b exp=%b%b", c, we1, we2, exp_we1, exp_we2); end
      if (exp_we1) begin
        checks++; if (add1 !== exp_add1 || wr1 !== exp_wr1) begin errors++; $display("FAIL rnd_port1 cyc=%0d got=%0d/%h exp=%0d/%h", c, add1, wr1, exp_add1, exp_wr1); end
      end
      if (exp_we2) begin
        checks++; if (add2 !== exp_add2 || wr2 !== exp_wr2) begin errors++; $display("FAIL rnd_port2 cyc=%0d got=%0d/%h exp=%0d/%h", c, add2, wr2, exp_add2, exp_wr2); end
      end
      checks++; if (coll_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_coll_cnt cyc=%0d got=%0d exp=%0d", c, coll_cnt, exp_cnt); end
      checks++; if (idle !== exp_idle) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", c, idle, exp_idle); end
    end
    for (int c = 0; c < 10; c++) idle_step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_rf[i] !== exp_rf[i]) begin errors++; $display("FAIL rnd_regfile r%0d got=%h exp=%h", i, dut_rf[i], exp_rf[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = 16'h0;
      dut_rf[i] = 16'h0;
    end
    test_reset();
    test_single();
    test_parallel();
    test_collision();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-back front end for the Neptune I v3.0 general purpose register array (16 x 8, dual write port).
- Accepts register write requests from two independent producers:
  - channel A: ALU result path;
  - channel B: load/move path.
- Each channel has its own valid/ready handshake and a small FIFO.
- Drives the array's two write ports (we1/add1/wr1 from A, we2/add2/wr2 from B) from registered outputs, and serialises same-address collisions so the array never sees two writes to one address in one cycle.

Parameters:
- width, 16, data width of a register write
- add_width, 3, register address width
- fifo_depth, 2, entries per channel FIFO (power of two, >= 2)
- cnt_width, 8, width of the collision counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  channel A request valid
- a_ready  out  1  channel A can accept (FIFO A not full)
- a_add  in  add_width  channel A destination register
- a_data  in  width  channel A write data
- b_valid  in  1  channel B request valid
- b_ready  out  1  channel B can accept (FIFO B not full)
- b_add  in  add_width  channel B destination register
- b_data  in  width  channel B write data
- we1  out  1  array port I write enable (registered)
- add1  out  add_width  array port I address (registered)
- wr1  out  width  array port I data (registered)
- we2  out  1  array port II write enable (registered)
- add2  out  add_width  array port II address (registered)
- wr2  out  width  array port II data (registered)
- idle  out  1  both FIFOs empty and we1 = we2 = 0
- coll_cnt  out  cnt_width  saturating count of collision stalls

Behaviour:
- Reset (rst = 1 at an edge):
  - FIFO pointers and counts cleared; all in-flight and queued requests dropped.
  - we1, we2, add1, add2, wr1, wr2 and coll_cnt forced to 0.
  - a_ready = b_ready = 1 after reset; idle = 1.
  - Reset has priority over every other event, including mid-collision.
- Handshake:
  - x_ready = !full_x, decoded combinationally from the registered count.
  - A push occurs at an edge when x_valid && x_ready.
  - When a FIFO is full, no push is accepted that cycle even if a pop occurs on the same edge; ready rises the following cycle.
  - Producers must hold add/data stable while valid && !ready.
- Issue (evaluated each cycle on the FIFO heads, registered at the edge):
  - Neither head valid: we1 = we2 = 0 next cycle.
  - Only A valid: pop A; we1 = 1 with A's add/data; we2 = 0.
  - Only B valid: pop B; we2 = 1 with B's add/data; we1 = 0.
  - Both valid, head addresses differ: pop both; we1 and we2 = 1 in the same cycle.
  - Both valid, head addresses equal (collision):
    - pop A only; we1 = 1, we2 = 0; B's head is held;
    - coll_cnt increments by 1, saturating at all-ones;
    - B issues on the next cycle, so B's value is the final register content.
- When a port's enable is 0, add/wr hold their last values; the verifier checks only enabled values.
- Latency:
  - Request accepted at edge N enters the FIFO.
  - With an empty FIFO and no collision, the registered write enable is asserted after edge N+1.
  - The array commits the write at edge N+2.
  - Each collision adds one cycle for B.
- A same-cycle push and pop on one FIFO is legal when it is not full; the count is unchanged.
- Pointers wrap modulo fifo_depth.
- Ordering: in-order per channel; no ordering is guaranteed between channels except on collision (A before B).
- Invariant: never (we1 && we2 && add1 == add2).
- idle is combinational from registered state; it is used by the pipeline drain/halt logic.

Decomposition:
- Shared defines file neptune_defs: data width 16, address width 3, register depth 8.
- One natural sub-module, wb_fifo: a synchronous FIFO parameterised by width+add_width and fifo_depth, with push/pop/full/empty/head. It is instantiated twice.
- Arbitration, output registers and coll_cnt live in reg_wb_arbiter.

Test Plan:
1. Reset: assert rst 2 cycles with a_valid = b_valid = 1 -> we1 = we2 = 0, coll_cnt = 0, a_ready = b_ready = 1, idle = 1; nothing is written.
2. Single write: A pushes add = 3, data = 16'hBEEF at edge N -> we1 = 1, add1 = 3, wr1 = 16'hBEEF after edge N+1; we1 = 0 the cycle after; idle returns to 1.
3. Parallel writes: same-cycle A add = 1 data = 16'h0011, B add = 2 data = 16'h0022 -> we1 and we2 both high in one cycle with those values; coll_cnt = 0.
4. Collision: same-cycle A add = 5 data = 16'h1111, B add = 5 data = 16'h2222 -> cycle 1: we1 = 1 (5, 1111), we2 = 0; cycle 2: we2 = 1 (5, 2222); coll_cnt = 1; a register read of r5 afterwards returns 16'h2222.
5. Backpressure: hold B valid with 3 back-to-back requests, each at add = 4 and colliding with A add = 4, depth 2 -> b_ready drops to 0 when full; all three B writes issue in order; no we1 && we2 with equal addresses ever occurs (assertion); coll_cnt saturates at 255 in a 300-collision run.
6. Reset mid-operation: both FIFOs full, assert rst for one cycle -> queued entries are never issued; outputs are 0 the next cycle; a fresh request afterwards completes with the latency of scenario 2.
